// File: rtl/arbitro_escritura_banco_if.sv
// Bus bundle for the two-requester register-bank write arbiter.
// master drives the write requests; slave is the arbiter itself.
interface arbitro_escritura_banco_if #(
    parameter int ANCHO_DATOS = 32,
    parameter int ANCHO_DIR   = 5
);
    logic                   req_valid_0;
    logic                   req_valid_1;
    logic                   req_ready_0;
    logic                   req_ready_1;
    logic [ANCHO_DIR-1:0]   req_addr_0;
    logic [ANCHO_DIR-1:0]   req_addr_1;
    logic [ANCHO_DATOS-1:0] req_data_0;
    logic [ANCHO_DATOS-1:0] req_data_1;
    logic                   write_enable;
    logic [ANCHO_DIR-1:0]   write_address;
    logic [ANCHO_DATOS-1:0] data_write;
    logic [1:0]             pendientes;

    modport master (
        output req_valid_0, req_valid_1,
        output req_addr_0, req_addr_1,
        output req_data_0, req_data_1,
        input  req_ready_0, req_ready_1,
        input  write_enable, write_address, data_write,
        input  pendientes
    );

    modport slave (
        input  req_valid_0, req_valid_1,
        input  req_addr_0, req_addr_1,
        input  req_data_0, req_data_1,
        output req_ready_0, req_ready_1,
        output write_enable, write_address, data_write,
        output pendientes
    );
endinterface

// File: rtl/arbitro_escritura_banco.sv
// Two-slot round-robin arbiter feeding a single register-bank write port.
// Optional macro REG_CERO_EN: writes to address 0 are swallowed (no strobe).
module arbitro_escritura_banco #(
    parameter int ANCHO_DATOS = 32,
    parameter int ANCHO_DIR   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    arbitro_escritura_banco_if.slave bus
);
    logic [1:0]             full_q, full_d;
    logic [ANCHO_DIR-1:0]   addr_q [2];
    logic [ANCHO_DATOS-1:0] data_q [2];
    logic                   ptr_q, ptr_d;
    logic                   we_q, we_d;
    logic [ANCHO_DIR-1:0]   wa_q, wa_d;
    logic [ANCHO_DATOS-1:0] wd_q, wd_d;
    logic [1:0]             pend_q, pend_d;

    logic [1:0] valid;
    logic [1:0] ready;
    logic [1:0] acc;
    logic [1:0] gnt;
    logic       any_gnt;
    logic       sel;
    logic       wr_ok;

    assign valid = {bus.req_valid_1, bus.req_valid_0};
    assign ready = ~full_q;
    assign acc   = valid & ready;

    assign bus.req_ready_0   = ready[0];
    assign bus.req_ready_1   = ready[1];
    assign bus.write_enable  = we_q;
    assign bus.write_address = wa_q;
    assign bus.data_write    = wd_q;
    assign bus.pendientes    = pend_q;

    // Grant selection: lone full slot wins, ties go to the pointer.
    always_comb begin
        any_gnt = |full_q;
        sel     = (&full_q) ? ptr_q : ~full_q[0];
        gnt     = 2'b00;
        if (any_gnt) begin
            gnt[sel] = 1'b1;
        end
`ifdef REG_CERO_EN
        wr_ok = (addr_q[sel] != '0);
`else
        wr_ok = 1'b1;
`endif
    end

    // Next state for slots, pointer and the registered write port.
    always_comb begin
        full_d = (full_q & ~gnt) | acc;
        ptr_d  = ptr_q;
        we_d   = 1'b0;
        wa_d   = wa_q;
        wd_d   = wd_q;
        if (any_gnt) begin
            ptr_d = ~sel;
            if (wr_ok) begin
                we_d = 1'b1;
                wa_d = addr_q[sel];
                wd_d = data_q[sel];
            end
        end
        pend_d = {1'b0, full_d[0]} + {1'b0, full_d[1]};
    end

    // Control state; reset discards pending slots and wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 2'b00;
            ptr_q  <= 1'b0;
            we_q   <= 1'b0;
            wa_q   <= '0;
            wd_q   <= '0;
            pend_q <= 2'd0;
        end else begin
            full_q <= full_d;
            ptr_q  <= ptr_d;
            we_q   <= we_d;
            wa_q   <= wa_d;
            wd_q   <= wd_d;
            pend_q <= pend_d;
        end
    end

    // Slot payload capture; only meaningful while the slot flag is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q[0] <= '0;
            addr_q[1] <= '0;
            data_q[0] <= '0;
            data_q[1] <= '0;
        end else begin
            if (acc[0]) begin
                addr_q[0] <= bus.req_addr_0;
                data_q[0] <= bus.req_data_0;
            end
            if (acc[1]) begin
                addr_q[1] <= bus.req_addr_1;
                data_q[1] <= bus.req_data_1;
            end
        end
    end
endmodule

// File: tb/tb_arbitro_escritura_banco.sv
// Directed bench for the register-bank write arbiter.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_arbitro_escritura_banco;
    localparam int AD = 32;
    localparam int AA = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    arbitro_escritura_banco_if #(.ANCHO_DATOS(AD), .ANCHO_DIR(AA)) bus ();

    arbitro_escritura_banco #(.ANCHO_DATOS(AD), .ANCHO_DIR(AA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid_0 = 1'b0;
        bus.req_valid_1 = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        bus.req_addr_0 = '0;
        bus.req_addr_1 = '0;
        bus.req_data_0 = '0;
        bus.req_data_1 = '0;

        // Reset held two cycles
        rst = 1'b1;
        tick();
        tick();
        chk("rst_we", bus.write_enable, 0);
        chk("rst_wa", bus.write_address, 0);
        chk("rst_wd", bus.data_write, 0);
        chk("rst_rdy0", bus.req_ready_0, 1);
        chk("rst_rdy1", bus.req_ready_1, 1);
        chk("rst_pend", bus.pendientes, 0);
        rst = 1'b0;

        // Single uncontended write
        bus.req_valid_0 = 1'b1;
        bus.req_addr_0  = 5'd3;
        bus.req_data_0  = 32'hDEADBEEF;
        tick();
        chk("s_rdy0", bus.req_ready_0, 0);
        chk("s_pend", bus.pendientes, 1);
        chk("s_we0", bus.write_enable, 0);
        idle();
        tick();
        chk("s_we1", bus.write_enable, 1);
        chk("s_wa", bus.write_address, 3);
        chk("s_wd", bus.data_write, 32'hDEADBEEF);
        chk("s_pend0", bus.pendientes, 0);
        chk("s_rdy0b", bus.req_ready_0, 1);
        tick();
        chk("s_we2", bus.write_enable, 0);
        chk("s_hold_wa", bus.write_address, 3);
        chk("s_hold_wd", bus.data_write, 32'hDEADBEEF);

        // Simultaneous accept after reset
        do_reset();
        bus.req_valid_0 = 1'b1;
        bus.req_addr_0  = 5'd5;
        bus.req_data_0  = 32'h11;
        bus.req_valid_1 = 1'b1;
        bus.req_addr_1  = 5'd6;
        bus.req_data_1  = 32'h22;
        tick();
        chk("b_pend2", bus.pendientes, 2);
        chk("b_rdy0", bus.req_ready_0, 0);
        chk("b_rdy1", bus.req_ready_1, 0);
        chk("b_we0", bus.write_enable, 0);
        idle();
        tick();
        chk("b_we1", bus.write_enable, 1);
        chk("b_wa1", bus.write_address, 5);
        chk("b_wd1", bus.data_write, 32'h11);
        chk("b_pend1", bus.pendientes, 1);
        tick();
        chk("b_we2", bus.write_enable, 1);
        chk("b_wa2", bus.write_address, 6);
        chk("b_wd2", bus.data_write, 32'h22);
        chk("b_pend0", bus.pendientes, 0);
        tick();
        chk("b_we3", bus.write_enable, 0);

        // Both continuously valid: alternating 0,1,0,1...
        do_reset();
        bus.req_valid_0 = 1'b1;
        bus.req_addr_0  = 5'd1;
        bus.req_data_0  = 32'hA0;
        bus.req_valid_1 = 1'b1;
        bus.req_addr_1  = 5'd2;
        bus.req_data_1  = 32'hB1;
        tick();
        chk("rr_rdy0_k1", bus.req_ready_0, 0);
        chk("rr_rdy1_k1", bus.req_ready_1, 0);
        for (int k = 2; k <= 9; k++) begin
            tick();
            chk($sformatf("rr_we_k%0d", k), bus.write_enable, 1);
            if (k % 2 == 0) begin
                chk($sformatf("rr_wa_k%0d", k), bus.write_address, 1);
                chk($sformatf("rr_wd_k%0d", k), bus.data_write, 32'hA0);
                chk($sformatf("rr_rdy0_k%0d", k), bus.req_ready_0, 1);
                chk($sformatf("rr_rdy1_k%0d", k), bus.req_ready_1, 0);
            end else begin
                chk($sformatf("rr_wa_k%0d", k), bus.write_address, 2);
                chk($sformatf("rr_wd_k%0d", k), bus.data_write, 32'hB1);
                chk($sformatf("rr_rdy0_k%0d", k), bus.req_ready_0, 0);
                chk($sformatf("rr_rdy1_k%0d", k), bus.req_ready_1, 1);
            end
            chk($sformatf("rr_pend_k%0d", k), bus.pendientes, 1);
        end
        idle();

        // Reset with both slots full discards them
        do_reset();
        bus.req_valid_0 = 1'b1;
        bus.req_addr_0  = 5'd7;
        bus.req_data_0  = 32'h70;
        bus.req_valid_1 = 1'b1;
        bus.req_addr_1  = 5'd8;
        bus.req_data_1  = 32'h80;
        tick();
        chk("mr_pend2", bus.pendientes, 2);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_pend0", bus.pendientes, 0);
        chk("mr_we_r", bus.write_enable, 0);
        chk("mr_rdy0", bus.req_ready_0, 1);
        chk("mr_rdy1", bus.req_ready_1, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mr_we_%0d", i), bus.write_enable, 0);
            chk($sformatf("mr_pend_%0d", i), bus.pendientes, 0);
        end

        // Address 0 write
        do_reset();
        bus.req_valid_1 = 1'b1;
        bus.req_addr_1  = 5'd0;
        bus.req_data_1  = 32'h55;
        tick();
        chk("z_pend1", bus.pendientes, 1);
        idle();
        tick();
        chk("z_pend0", bus.pendientes, 0);
`ifdef REG_CERO_EN
        chk("z_we", bus.write_enable, 0);
        chk("z_wd_hold", bus.data_write, 0);
`else
        chk("z_we", bus.write_enable, 1);
        chk("z_wa", bus.write_address, 0);
        chk("z_wd", bus.data_write, 32'h55);
`endif
        tick();
        chk("z_we_after", bus.write_enable, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
